axi_perf_monitor: RTL and testbench
===================================

Name: axi_perf_monitor

Overview:
- Synthesizable AXI4 performance monitor; successor to the trace-only simulation monitor.
- Passively snoops all five channels of one AXI port.
- Per direction: tracks outstanding transactions by ID, measures address-to-response latency, accumulates windowed statistics.
- Emits one statistics record per window over a valid/ready handshake; sits beside any NoC endpoint for silicon/FPGA profiling.

Parameters:
- ID_WIDTH, 4, width of AWID/BID/ARID/RID
- DATA_WIDTH, 32, data bus width (bytes per beat = DATA_WIDTH/8)
- MAX_OUTST, 8, tracking-table entries per direction (power of 2, ≥2)
- WINDOW_CYCLES, 1024, sample window length in cycles (≥16)
- CNT_WIDTH, 32, width of count and sum accumulators
- LAT_WIDTH, 16, width of per-entry age counter and latency max

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous active-high reset
- AWID  in  ID_WIDTH  write address ID
- AWVALID/AWREADY  in  1 each  AW handshake
- WLAST/WVALID/WREADY  in  1 each  W handshake
- BID  in  ID_WIDTH  write response ID
- BVALID/BREADY  in  1 each  B handshake
- ARID  in  ID_WIDTH  read address ID
- ARVALID/ARREADY  in  1 each  AR handshake
- RID  in  ID_WIDTH  read data ID
- RLAST/RVALID/RREADY  in  1 each  R handshake
- mon_clear  in  1  synchronous restart of window and accumulators
- stat_ready  in  1  consumer accepts record
- stat_valid  out  1  record available
- stat_rd_txn, stat_wr_txn  out  CNT_WIDTH each  completed transactions (RLAST / B)
- stat_rd_beats, stat_wr_beats  out  CNT_WIDTH each  R / W beats
- stat_rd_lat_sum, stat_wr_lat_sum  out  CNT_WIDTH each  summed latency of matched completions
- stat_rd_lat_max, stat_wr_lat_max  out  LAT_WIDTH each  max latency
- stat_flags  out  5  {lost, wr_orphan, rd_orphan, wr_full, rd_full}
- rd_outstanding, wr_outstanding  out  $clog2(MAX_OUTST)+1 each  live table occupancy

Behaviour:
- Reset: all outputs 0, all table entries invalid, window counter 0, accumulators 0.
- ARESET mid-operation discards in-flight entries; responses arriving afterwards count as orphans.
- Allocation:
  - AR handshake allocates the lowest-index free read entry {id, age=0}; AW does the same in the write table.
  - Table full: no allocation, full flag set for the window.
  - A same-cycle free does not make room for an allocation in that cycle.
- Age: every valid entry increments its age each cycle, saturating at 2^LAT_WIDTH-1.
- Completion:
  - R handshake with RLAST, or any B handshake, matches the valid entry with the same ID and the largest age.
  - Tie on age: lowest index wins.
  - Matched entry freed; latency = age+1 (address handshake in cycle N, response in N+3 → 3).
  - An entry allocated in the current cycle is never matched in that cycle.
  - No match: orphan flag set; txn still counted; latency not accumulated.
- Beats: each R handshake increments rd_beats; each W handshake increments wr_beats. W is not tied to AW.
- Accumulators and counts saturate at all-ones. Max updates with the larger value.
- Window:
  - Counter runs 0..WINDOW_CYCLES-1.
  - On the final cycle, accumulators plus that cycle's events load into the stat registers; stat_valid=1 next cycle.
  - Accumulators restart at 0.
- Output handshake:
  - Record held stable while stat_valid && !stat_ready.
  - stat_valid clears cycle after stat_valid && stat_ready.
  - New snapshot while previous record unaccepted: overwrite, set lost flag in the new record.
  - Snapshot coincident with acceptance: new record loads, stat_valid stays 1, lost=0.
- mon_clear:
  - Zeroes window counter and accumulators next cycle; no snapshot.
  - Tables and the output record are untouched.
  - Takes priority over a coincident window end.
- Occupancy: rd/wr_outstanding reflect the table after this cycle's alloc/free, registered.

Decomposition:
- Package axi_perf_pkg: stat record struct (counts, sums, maxima, flags), flag bit-index constants, function sat_add.
- Sub-module axi_lat_tracker: one table (alloc, age, oldest-ID match, free, occupancy), instantiated for read and write; outputs done, orphan, full, latency.

Test Plan:
- Single AR ID=3 at cycle 10, 4 R beats, RLAST at cycle 20 → record rd_txn=1, rd_beats=4, rd_lat_sum=10, rd_lat_max=10, flags=0.
- Two AW ID=1 (cycles 5, 7), B ID=1 at 12 and 30 → first B matches the cycle-5 entry; wr_lat_sum=7+23=30, wr_lat_max=23.
- 9 ARs without responses, MAX_OUTST=8 → rd_outstanding=8, rd_full=1, 9th untracked; later 9 RLASTs → 8 matched, rd_orphan=1.
- stat_ready held 0 across two windows → second record has lost=1 with only the second window's counts; raising stat_ready drops stat_valid next cycle.
- ARESET asserted with 3 reads outstanding, then their RLASTs → outputs 0 during reset; next record rd_txn=3, rd_orphan=1, rd_lat_sum=0.
- mon_clear pulsed in a window's last cycle → no snapshot that cycle; next record covers exactly WINDOW_CYCLES cycles from the clear.

Source files
------------

// File: rtl/axi_perf_pkg.sv
`default_nettype none
// axi_perf_pkg: flag bit positions and saturating arithmetic shared by the AXI performance monitor.
// Revision: 1.0
package axi_perf_pkg;

  localparam int FLAG_RD_FULL   = 0;
  localparam int FLAG_WR_FULL   = 1;
  localparam int FLAG_RD_ORPHAN = 2;
  localparam int FLAG_WR_ORPHAN = 3;
  localparam int FLAG_LOST      = 4;
  localparam int NUM_FLAGS      = 5;

  // Adds two unsigned values and clamps the result to the all-ones value of 'width' bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int width);
    logic [64:0] sum;
    logic [63:0] lim;
    lim = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[63:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_perf_monitor_tracker.sv
`default_nettype none
// axi_lat_tracker: outstanding-transaction table for one AXI direction with per-entry age,
// oldest-same-ID completion matching and registered occupancy.  Revision: 1.0
module axi_lat_tracker #(
  parameter int ID_WIDTH  = 4,
  parameter int MAX_OUTST = 8,
  parameter int LAT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc,
  input  logic [ID_WIDTH-1:0]          alloc_id,
  input  logic                         resp,
  input  logic [ID_WIDTH-1:0]          resp_id,
  output logic                         done,
  output logic                         orphan,
  output logic                         full,
  output logic [LAT_WIDTH-1:0]         latency,
  output logic [$clog2(MAX_OUTST):0]   occupancy
);
  localparam int IDX_W = $clog2(MAX_OUTST);
  localparam int OCC_W = IDX_W + 1;

  logic [MAX_OUTST-1:0] valid, valid_next;
  logic [ID_WIDTH-1:0]  ids  [MAX_OUTST];
  logic [LAT_WIDTH-1:0] ages [MAX_OUTST];
  logic                 have_free, have_match, do_alloc, do_free;
  logic [IDX_W-1:0]     free_idx, match_idx;
  logic [LAT_WIDTH-1:0] match_age;
  logic [OCC_W-1:0]     occ_next;

  // Search uses the registered table only, so a same-cycle free never makes room
  // and a same-cycle allocation is never matched.
  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    for (int i = MAX_OUTST - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end
    have_match = 1'b0;
    match_idx  = '0;
    match_age  = '0;
    for (int i = 0; i < MAX_OUTST; i++) begin
      if (valid[i] && ids[i] == resp_id && (!have_match || ages[i] > match_age)) begin
        have_match = 1'b1;
        match_idx  = IDX_W'(i);
        match_age  = ages[i];
      end
    end
  end

  assign do_alloc = alloc && have_free;
  assign do_free  = resp && have_match;
  assign done     = resp;
  assign orphan   = resp && !have_match;
  assign full     = alloc && !have_free;
  assign latency  = !do_free ? '0 : ((&match_age) ? match_age : match_age + LAT_WIDTH'(1));

  always_comb begin
    valid_next = valid;
    if (do_free)  valid_next[match_idx] = 1'b0;
    if (do_alloc) valid_next[free_idx]  = 1'b1;
    occ_next = '0;
    for (int i = 0; i < MAX_OUTST; i++) occ_next = occ_next + OCC_W'(valid_next[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= '0;
      occupancy <= '0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        ids[i]  <= '0;
        ages[i] <= '0;
      end
    end else begin
      valid     <= valid_next;
      occupancy <= occ_next;
      for (int i = 0; i < MAX_OUTST; i++) begin
        if (do_alloc && free_idx == IDX_W'(i)) begin
          ids[i]  <= alloc_id;
          ages[i] <= '0;
        end else if (valid[i] && !(&ages[i])) begin
          ages[i] <= ages[i] + LAT_WIDTH'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_perf_monitor.sv
`default_nettype none
// axi_perf_monitor: passive AXI4 snooper producing one windowed latency/throughput record
// per WINDOW_CYCLES over a valid/ready handshake.  Revision: 1.0
module axi_perf_monitor
  import axi_perf_pkg::*;
#(
  parameter int ID_WIDTH      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_OUTST     = 8,
  parameter int WINDOW_CYCLES = 1024,
  parameter int CNT_WIDTH     = 32,
  parameter int LAT_WIDTH     = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [ID_WIDTH-1:0]          AWID,
  input  logic                         AWVALID,
  input  logic                         AWREADY,
  input  logic                         WLAST,
  input  logic                         WVALID,
  input  logic                         WREADY,
  input  logic [ID_WIDTH-1:0]          BID,
  input  logic                         BVALID,
  input  logic                         BREADY,
  input  logic [ID_WIDTH-1:0]          ARID,
  input  logic                         ARVALID,
  input  logic                         ARREADY,
  input  logic [ID_WIDTH-1:0]          RID,
  input  logic                         RLAST,
  input  logic                         RVALID,
  input  logic                         RREADY,
  input  logic                         mon_clear,
  input  logic                         stat_ready,
  output logic                         stat_valid,
  output logic [CNT_WIDTH-1:0]         stat_rd_txn,
  output logic [CNT_WIDTH-1:0]         stat_wr_txn,
  output logic [CNT_WIDTH-1:0]         stat_rd_beats,
  output logic [CNT_WIDTH-1:0]         stat_wr_beats,
  output logic [CNT_WIDTH-1:0]         stat_rd_lat_sum,
  output logic [CNT_WIDTH-1:0]         stat_wr_lat_sum,
  output logic [LAT_WIDTH-1:0]         stat_rd_lat_max,
  output logic [LAT_WIDTH-1:0]         stat_wr_lat_max,
  output logic [NUM_FLAGS-1:0]         stat_flags,
  output logic [$clog2(MAX_OUTST):0]   rd_outstanding,
  output logic [$clog2(MAX_OUTST):0]   wr_outstanding
);
  localparam int WIN_W = $clog2(WINDOW_CYCLES);

  typedef struct packed {
    logic [CNT_WIDTH-1:0] rd_txn;
    logic [CNT_WIDTH-1:0] wr_txn;
    logic [CNT_WIDTH-1:0] rd_beats;
    logic [CNT_WIDTH-1:0] wr_beats;
    logic [CNT_WIDTH-1:0] rd_lat_sum;
    logic [CNT_WIDTH-1:0] wr_lat_sum;
    logic [LAT_WIDTH-1:0] rd_lat_max;
    logic [LAT_WIDTH-1:0] wr_lat_max;
    logic [NUM_FLAGS-1:0] flags;
  } stat_rec_t;

  function automatic logic [CNT_WIDTH-1:0] add_cnt(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    return CNT_WIDTH'(sat_add(64'(a), 64'(b), CNT_WIDTH));
  endfunction

  logic                 rd_done, rd_orphan, rd_full, wr_done, wr_orphan, wr_full;
  logic                 rd_hit, wr_hit;
  logic [LAT_WIDTH-1:0] rd_lat, wr_lat;
  stat_rec_t            acc, acc_next, snap, rec;
  logic [WIN_W-1:0]     win_cnt;
  logic                 win_end;
  logic                 unused_ok;

  // Write beats are counted independently of AW, so WLAST and the bus width carry no information here.
  assign unused_ok = ^{WLAST, 32'(DATA_WIDTH)};

  axi_lat_tracker #(.ID_WIDTH(ID_WIDTH), .MAX_OUTST(MAX_OUTST), .LAT_WIDTH(LAT_WIDTH)) u_rd_trk (
    .clk(ACLK), .rst(ARESET),
    .alloc(ARVALID && ARREADY), .alloc_id(ARID),
    .resp(RVALID && RREADY && RLAST), .resp_id(RID),
    .done(rd_done), .orphan(rd_orphan), .full(rd_full), .latency(rd_lat),
    .occupancy(rd_outstanding)
  );

  axi_lat_tracker #(.ID_WIDTH(ID_WIDTH), .MAX_OUTST(MAX_OUTST), .LAT_WIDTH(LAT_WIDTH)) u_wr_trk (
    .clk(ACLK), .rst(ARESET),
    .alloc(AWVALID && AWREADY), .alloc_id(AWID),
    .resp(BVALID && BREADY), .resp_id(BID),
    .done(wr_done), .orphan(wr_orphan), .full(wr_full), .latency(wr_lat),
    .occupancy(wr_outstanding)
  );

  assign rd_hit  = rd_done && !rd_orphan;
  assign wr_hit  = wr_done && !wr_orphan;
  assign win_end = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));

  always_comb begin
    acc_next            = acc;
    acc_next.rd_txn     = add_cnt(acc.rd_txn, CNT_WIDTH'(rd_done));
    acc_next.wr_txn     = add_cnt(acc.wr_txn, CNT_WIDTH'(wr_done));
    acc_next.rd_beats   = add_cnt(acc.rd_beats, CNT_WIDTH'(RVALID && RREADY));
    acc_next.wr_beats   = add_cnt(acc.wr_beats, CNT_WIDTH'(WVALID && WREADY));
    acc_next.rd_lat_sum = rd_hit ? add_cnt(acc.rd_lat_sum, CNT_WIDTH'(rd_lat)) : acc.rd_lat_sum;
    acc_next.wr_lat_sum = wr_hit ? add_cnt(acc.wr_lat_sum, CNT_WIDTH'(wr_lat)) : acc.wr_lat_sum;
    acc_next.rd_lat_max = (rd_hit && rd_lat > acc.rd_lat_max) ? rd_lat : acc.rd_lat_max;
    acc_next.wr_lat_max = (wr_hit && wr_lat > acc.wr_lat_max) ? wr_lat : acc.wr_lat_max;
    acc_next.flags[FLAG_RD_FULL]   = acc.flags[FLAG_RD_FULL]   | rd_full;
    acc_next.flags[FLAG_WR_FULL]   = acc.flags[FLAG_WR_FULL]   | wr_full;
    acc_next.flags[FLAG_RD_ORPHAN] = acc.flags[FLAG_RD_ORPHAN] | rd_orphan;
    acc_next.flags[FLAG_WR_ORPHAN] = acc.flags[FLAG_WR_ORPHAN] | wr_orphan;
    snap                 = acc_next;
    // Lost marks that the record being replaced was never accepted.
    snap.flags[FLAG_LOST] = stat_valid && !stat_ready;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      win_cnt    <= '0;
      acc        <= '0;
      rec        <= '0;
      stat_valid <= 1'b0;
    end else begin
      if (mon_clear) begin
        win_cnt <= '0;
        acc     <= '0;
      end else if (win_end) begin
        win_cnt <= '0;
        acc     <= '0;
        rec     <= snap;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        acc     <= acc_next;
      end
      if (!mon_clear && win_end) stat_valid <= 1'b1;
      else if (stat_ready)       stat_valid <= 1'b0;
    end
  end

  assign stat_rd_txn     = rec.rd_txn;
  assign stat_wr_txn     = rec.wr_txn;
  assign stat_rd_beats   = rec.rd_beats;
  assign stat_wr_beats   = rec.wr_beats;
  assign stat_rd_lat_sum = rec.rd_lat_sum;
  assign stat_wr_lat_sum = rec.wr_lat_sum;
  assign stat_rd_lat_max = rec.rd_lat_max;
  assign stat_wr_lat_max = rec.wr_lat_max;
  assign stat_flags      = rec.flags;

endmodule
`default_nettype wire

// File: tb/tb_axi_perf_monitor.sv
`default_nettype none
// tb_axi_perf_monitor: directed stimulus with a record scoreboard for axi_perf_monitor.
// Revision: 1.0
module tb_axi_perf_monitor;
  localparam int IDW = 4;
  localparam int W   = 64;
  localparam int CW  = 32;
  localparam int LW  = 16;

  logic clk = 1'b0;
  logic ARESET, mon_clear, stat_ready, stat_valid;
  logic [IDW-1:0] AWID, BID, ARID, RID;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [CW-1:0] stat_rd_txn, stat_wr_txn, stat_rd_beats, stat_wr_beats;
  logic [CW-1:0] stat_rd_lat_sum, stat_wr_lat_sum;
  logic [LW-1:0] stat_rd_lat_max, stat_wr_lat_max;
  logic [4:0]    stat_flags;
  logic [3:0]    rd_outstanding, wr_outstanding;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int unsigned rd_txn, wr_txn, rd_beats, wr_beats, rd_sum, wr_sum, rd_max, wr_max;
    logic [4:0]  flags;
  } exp_t;
  exp_t exp_q[$];

  axi_perf_monitor #(.ID_WIDTH(IDW), .DATA_WIDTH(32), .MAX_OUTST(8), .WINDOW_CYCLES(W),
                     .CNT_WIDTH(CW), .LAT_WIDTH(LW)) dut (
    .ACLK(clk), .ARESET(ARESET),
    .AWID(AWID), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mon_clear(mon_clear), .stat_ready(stat_ready), .stat_valid(stat_valid),
    .stat_rd_txn(stat_rd_txn), .stat_wr_txn(stat_wr_txn),
    .stat_rd_beats(stat_rd_beats), .stat_wr_beats(stat_wr_beats),
    .stat_rd_lat_sum(stat_rd_lat_sum), .stat_wr_lat_sum(stat_wr_lat_sum),
    .stat_rd_lat_max(stat_rd_lat_max), .stat_wr_lat_max(stat_wr_lat_max),
    .stat_flags(stat_flags),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(int unsigned rt, int unsigned wt, int unsigned rb, int unsigned wb,
                              int unsigned rs, int unsigned ws, int unsigned rm, int unsigned wm,
                              logic [4:0] fl);
    exp_t e;
    e.rd_txn = rt; e.wr_txn = wt; e.rd_beats = rb; e.wr_beats = wb;
    e.rd_sum = rs; e.wr_sum = ws; e.rd_max = rm; e.wr_max = wm; e.flags = fl;
    return e;
  endfunction

  // Monitor: a record is consumed at the edge following a sample where valid and ready are both high.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!ARESET && stat_valid && stat_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", 64'(stat_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rec_rd_txn",   64'(stat_rd_txn),     64'(e.rd_txn));
        check("rec_wr_txn",   64'(stat_wr_txn),     64'(e.wr_txn));
        check("rec_rd_beats", 64'(stat_rd_beats),   64'(e.rd_beats));
        check("rec_wr_beats", 64'(stat_wr_beats),   64'(e.wr_beats));
        check("rec_rd_sum",   64'(stat_rd_lat_sum), 64'(e.rd_sum));
        check("rec_wr_sum",   64'(stat_wr_lat_sum), 64'(e.wr_sum));
        check("rec_rd_max",   64'(stat_rd_lat_max), 64'(e.rd_max));
        check("rec_wr_max",   64'(stat_wr_lat_max), 64'(e.wr_max));
        check("rec_flags",    64'(stat_flags),      64'(e.flags));
      end
    end
  end

  task automatic idle();
    mon_clear = 1'b0;
    AWVALID = 1'b0; AWID = '0; AWREADY = 1'b1;
    WVALID = 1'b0; WLAST = 1'b0; WREADY = 1'b1;
    BVALID = 1'b0; BID = '0; BREADY = 1'b1;
    ARVALID = 1'b0; ARID = '0; ARREADY = 1'b1;
    RVALID = 1'b0; RID = '0; RLAST = 1'b0; RREADY = 1'b1;
  endtask

  task automatic ar(input int id); ARVALID = 1'b1; ARID = IDW'(id); endtask
  task automatic aw(input int id); AWVALID = 1'b1; AWID = IDW'(id); endtask
  task automatic b(input int id);  BVALID = 1'b1; BID = IDW'(id); endtask
  task automatic w();              WVALID = 1'b1; WLAST = 1'b1; endtask
  task automatic r(input int id, input bit last);
    RVALID = 1'b1; RID = IDW'(id); RLAST = last;
  endtask

  // Clear lands on the next edge; the following W edges form one window.
  task automatic start_window();
    idle();
    mon_clear = 1'b1;
    @(negedge clk);
    mon_clear = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1; stat_ready = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    check("reset_stat_valid", 64'(stat_valid), 64'd0);
    check("reset_rd_outst",   64'(rd_outstanding), 64'd0);
    ARESET = 1'b0;

    // Single read: AR at 10, beats 17..20, RLAST at 20 -> latency 10; a stalled beat at 16 is ignored.
    exp_q.push_back(mk(1, 0, 4, 0, 10, 0, 10, 0, 5'b00000));
    start_window();
    for (int c = 1; c <= W; c++) begin
      idle();
      if (c == 10) ar(3);
      if (c == 16) begin r(3, 1'b0); RREADY = 1'b0; end
      if (c >= 17 && c <= 20) r(3, c == 20);
      if (c == 15) check("t1_rd_outst_live", 64'(rd_outstanding), 64'd1);
      @(negedge clk);
    end
    check("t1_rd_outst_end", 64'(rd_outstanding), 64'd0);

    // Two writes with the same ID: oldest matched first -> 7 and 23.
    exp_q.push_back(mk(0, 2, 0, 3, 0, 30, 0, 23, 5'b00000));
    start_window();
    for (int c = 1; c <= W; c++) begin
      idle();
      if (c == 5 || c == 7) aw(1);
      if (c >= 8 && c <= 10) w();
      if (c == 12 || c == 30) b(1);
      if (c == 9) check("t2_wr_outst_live", 64'(wr_outstanding), 64'd2);
      if (c == 20) check("t2_wr_outst_after_b", 64'(wr_outstanding), 64'd1);
      @(negedge clk);
    end

    // Nine reads into an eight-entry table, then nine RLASTs: eight at latency 19, one orphan.
    exp_q.push_back(mk(9, 0, 9, 0, 152, 0, 19, 0, 5'b00101));
    start_window();
    for (int c = 1; c <= W; c++) begin
      idle();
      if (c >= 1 && c <= 9) ar(c - 1);
      if (c >= 20 && c <= 28) r(c - 20, 1'b1);
      if (c == 15) check("t3_rd_outst_full", 64'(rd_outstanding), 64'd8);
      @(negedge clk);
    end
    check("t3_rd_outst_end", 64'(rd_outstanding), 64'd0);
    @(negedge clk);

    // Consumer stalls across two windows: only the second window survives, with lost set.
    stat_ready = 1'b0;
    exp_q.push_back(mk(0, 1, 0, 2, 0, 10, 0, 10, 5'b10000));
    start_window();
    for (int c = 1; c <= 2 * W; c++) begin
      idle();
      if (c == 2) ar(2);
      if (c == 6) r(2, 1'b1);
      if (c == W + 3) aw(5);
      if (c == W + 5 || c == W + 6) w();
      if (c == W + 13) b(5);
      if (c == W + 5) begin
        check("t4_held_valid",  64'(stat_valid),  64'd1);
        check("t4_held_rd_txn", 64'(stat_rd_txn), 64'd1);
        check("t4_held_rd_max", 64'(stat_rd_lat_max), 64'd4);
      end
      @(negedge clk);
    end
    check("t4_valid_before_ready", 64'(stat_valid), 64'd1);
    stat_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_after_accept", 64'(stat_valid), 64'd0);

    // Reset with three reads in flight: their RLASTs afterwards are orphans.
    start_window();
    for (int c = 1; c <= 6; c++) begin
      idle();
      if (c >= 2 && c <= 4) ar(c - 1);
      @(negedge clk);
    end
    check("t5_rd_outst_pre", 64'(rd_outstanding), 64'd3);
    ARESET = 1'b1;
    #1;
    check("t5_rst_rd_outst", 64'(rd_outstanding), 64'd0);
    check("t5_rst_wr_txn",   64'(stat_wr_txn), 64'd0);
    check("t5_rst_flags",    64'(stat_flags), 64'd0);
    repeat (2) @(negedge clk);
    ARESET = 1'b0;
    exp_q.push_back(mk(3, 0, 3, 0, 0, 0, 0, 0, 5'b00100));
    for (int c = 1; c <= W; c++) begin
      idle();
      if (c >= 5 && c <= 7) r(c - 4, 1'b1);
      @(negedge clk);
    end

    // Clear in the last cycle of a window: no snapshot, next record spans W edges from the clear.
    exp_q.push_back(mk(0, 1, 2, 0, 0, W - 1, 0, W - 1, 5'b00000));
    for (int c = 1; c <= 2 * W; c++) begin
      idle();
      if (c == 3) ar(4);
      if (c == 8) r(4, 1'b1);
      if (c == W) begin mon_clear = 1'b1; r(9, 1'b0); end
      if (c == W + 1) begin
        check("t6_no_snapshot_on_clear", 64'(stat_valid), 64'd0);
        r(9, 1'b0);
        aw(7);
      end
      if (c == 2 * W) begin r(9, 1'b0); b(7); end
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
